regfile_wb_arbiter: RTL and testbench

- Sequences the single register-file write port between three sources: the in-order pipeline writeback and two long-latency units, MDU (requester 0) and LSU miss return (requester 1).
- Holds a destination scoreboard so issue logic can stall on registers with pending long-latency writes.
- Applies a starvation guard so the pipeline cannot lock out the long-latency units.
- Sits between the writeback stage and the register file; its registered write outputs drive the register file write port directly.

---
 rtl/regfile_wb_arbiter.sv | 153 +++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter with destination scoreboard
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   pipe_wen/waddr/wdata          in-order pipeline writeback
//   req_valid/addr/data, req_ready long-latency write requests {lsu, mdu}
//   alloc_en/unit/addr            long-latency issue, marks destination busy
//   chk_addr_1/2, busy_1/2        issue-side scoreboard lookup
//   stall_pipe                    pipeline must hold its writeback this cycle
//   write_en/addr/data            registered register-file write port

module regfile_wb_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pipe_wen,
  input  logic [ADDR_W-1:0]   pipe_waddr,
  input  logic [DATA_W-1:0]   pipe_wdata,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          req_ready,
  input  logic                alloc_en,
  input  logic                alloc_unit,
  input  logic [ADDR_W-1:0]   alloc_addr,
  input  logic [ADDR_W-1:0]   chk_addr_1,
  input  logic [ADDR_W-1:0]   chk_addr_2,
  output logic                busy_1,
  output logic                busy_2,
  output logic                stall_pipe,
  output logic                write_en,
  output logic [ADDR_W-1:0]   write_addr,
  output logic [DATA_W-1:0]   write_data
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [NREG-1:0]             busy_q, busy_d;
  logic [NREG-1:0]             owner_q, owner_d;
  logic                        rr_q, rr_d;
  logic [1:0][CNT_W-1:0]       wait_q, wait_d;
  logic                        stall_q, stall_d;
  logic                        write_en_q, write_en_d;
  logic [ADDR_W-1:0]           write_addr_q, write_addr_d;
  logic [DATA_W-1:0]           write_data_q, write_data_d;

  logic [1:0]                  starved;
  logic                        gnt_pipe, gnt_ll, gnt_unit;
  logic [ADDR_W-1:0]           ll_addr;
  logic [DATA_W-1:0]           ll_data;

  assign starved[0] = (wait_q[0] == LIMIT);
  assign starved[1] = (wait_q[1] == LIMIT);

  // Arbitration: stall cycle serves the starved unit, else pipeline, else round robin.
  always_comb begin
    gnt_pipe = 1'b0;
    gnt_ll   = 1'b0;
    gnt_unit = 1'b0;
    rr_d     = rr_q;
    if (!rst) begin
      if (stall_q) begin
        gnt_ll = |req_valid;
        if (req_valid[0] && starved[0])      gnt_unit = 1'b0;
        else if (req_valid[1] && starved[1]) gnt_unit = 1'b1;
        else if (req_valid == 2'b11)         gnt_unit = rr_q;
        else                                 gnt_unit = req_valid[1];
      end else if (pipe_wen) begin
        gnt_pipe = 1'b1;
      end else if (|req_valid) begin
        gnt_ll = 1'b1;
        if (req_valid == 2'b11) begin
          gnt_unit = rr_q;
          rr_d     = ~rr_q;
        end else begin
          gnt_unit = req_valid[1];
        end
      end
    end
  end

  assign req_ready = gnt_ll ? (gnt_unit ? 2'b10 : 2'b01) : 2'b00;
  assign ll_addr   = gnt_unit ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign ll_data   = gnt_unit ? req_data[2*DATA_W-1:DATA_W] : req_data[DATA_W-1:0];

  // Write port, wait counters and stall request.
  always_comb begin
    write_en_d   = gnt_pipe | gnt_ll;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (gnt_pipe) begin
      write_addr_d = pipe_waddr;
      write_data_d = pipe_wdata;
    end else if (gnt_ll) begin
      write_addr_d = ll_addr;
      write_data_d = ll_data;
    end
    for (int i = 0; i < 2; i++) begin
      if (!req_valid[i] || req_ready[i]) wait_d[i] = '0;
      else if (!starved[i])              wait_d[i] = wait_q[i] + CNT_W'(1);
      else                               wait_d[i] = wait_q[i];
    end
    // Never two stall cycles back to back.
    stall_d = !stall_q && (|starved);
  end

  // Scoreboard: owner-checked clear from grants, then alloc overrides.
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    if (gnt_ll && owner_q[ll_addr] == gnt_unit) busy_d[ll_addr] = 1'b0;
    if (alloc_en) begin
      busy_d[alloc_addr]  = 1'b1;
      owner_d[alloc_addr] = alloc_unit;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q       <= '0;
      owner_q      <= '0;
      rr_q         <= 1'b0;
      wait_q       <= '0;
      stall_q      <= 1'b0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      wait_q       <= wait_d;
      stall_q      <= stall_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign busy_1     = busy_q[chk_addr_1];
  assign busy_2     = busy_q[chk_addr_2];
  assign stall_pipe = stall_q;
  assign write_en   = write_en_q;
  assign write_addr = write_addr_q;
  assign write_data = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter

module tb_regfile_wb_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                pipe_wen;
  logic [ADDR_W-1:0]   pipe_waddr;
  logic [DATA_W-1:0]   pipe_wdata;
  logic [1:0]          req_valid;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_data;
  logic [1:0]          req_ready;
  logic                alloc_en;
  logic                alloc_unit;
  logic [ADDR_W-1:0]   alloc_addr;
  logic [ADDR_W-1:0]   chk_addr_1;
  logic [ADDR_W-1:0]   chk_addr_2;
  logic                busy_1;
  logic                busy_2;
  logic                stall_pipe;
  logic                write_en;
  logic [ADDR_W-1:0]   write_addr;
  logic [DATA_W-1:0]   write_data;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .alloc_en(alloc_en), .alloc_unit(alloc_unit), .alloc_addr(alloc_addr),
    .chk_addr_1(chk_addr_1), .chk_addr_2(chk_addr_2), .busy_1(busy_1), .busy_2(busy_2),
    .stall_pipe(stall_pipe), .write_en(write_en), .write_addr(write_addr), .write_data(write_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pipe_wen = 1'b0; pipe_waddr = '0; pipe_wdata = '0;
    req_valid = 2'b00; req_addr = '0; req_data = '0;
    alloc_en = 1'b0; alloc_unit = 1'b0; alloc_addr = '0;
    chk_addr_1 = 5'd7; chk_addr_2 = 5'd3;
    step(); step();
    req_valid = 2'b11; #1;
    check_eq("ready_in_reset", req_ready, 2'b00);
    rst = 1'b0; req_valid = 2'b00;
    step();
    check_eq("rst_write_en", write_en, 0);
    check_eq("rst_stall", stall_pipe, 0);
    check_eq("rst_ready", req_ready, 2'b00);
    check_eq("rst_busy_1", busy_1, 0);
    check_eq("rst_busy_2", busy_2, 0);

    // Pipeline beats a single long-latency requester.
    pipe_wen = 1'b1; pipe_waddr = 5'd5; pipe_wdata = 32'hDEADBEEF; req_valid = 2'b01; #1;
    check_eq("pipe_ready", req_ready, 2'b00);
    step();
    pipe_wen = 1'b0; req_valid = 2'b00;
    check_eq("pipe_wen", write_en, 1);
    check_eq("pipe_waddr", write_addr, 5);
    check_eq("pipe_wdata", write_data, 32'hDEADBEEF);
    step();
    check_eq("idle_wen", write_en, 0);

    // Scoreboard set by alloc, cleared by the owning MDU grant.
    alloc_en = 1'b1; alloc_unit = 1'b0; alloc_addr = 5'd7;
    step();
    alloc_en = 1'b0; chk_addr_1 = 5'd7; #1;
    check_eq("sb_busy_set", busy_1, 1);
    req_valid = 2'b01; req_addr = {5'd0, 5'd7}; req_data = {32'h0, 32'h12}; #1;
    check_eq("mdu_ready", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    check_eq("mdu_wen", write_en, 1);
    check_eq("mdu_waddr", write_addr, 7);
    check_eq("mdu_wdata", write_data, 32'h12);
    check_eq("sb_busy_clr", busy_1, 0);

    // Round robin with both requesters held.
    req_valid = 2'b11; req_addr = {5'd20, 5'd10}; req_data = {32'hB, 32'hA};
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("rr_ready_%0d", i), req_ready, (i % 2) ? 2'b10 : 2'b01);
      step();
      check_eq($sformatf("rr_waddr_%0d", i), write_addr, (i % 2) ? 20 : 10);
      check_eq($sformatf("rr_wdata_%0d", i), write_data, (i % 2) ? 32'hB : 32'hA);
    end
    req_valid = 2'b00;
    step();

    // Starvation guard: LSU blocked by a continuous pipeline stream.
    pipe_wen = 1'b1; pipe_waddr = 5'd9; pipe_wdata = 32'h99;
    req_valid = 2'b10; req_addr = {5'd12, 5'd0}; req_data = {32'h55, 32'h0};
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("starve_stall_%0d", i), stall_pipe, 0);
      check_eq($sformatf("starve_ready_%0d", i), req_ready, 2'b00);
      step();
    end
    check_eq("stall_on", stall_pipe, 1);
    check_eq("stall_ready", req_ready, 2'b10);
    step();
    check_eq("stall_off", stall_pipe, 0);
    check_eq("stall_wen", write_en, 1);
    check_eq("stall_waddr", write_addr, 12);
    check_eq("stall_wdata", write_data, 32'h55);
    pipe_wen = 1'b0; req_valid = 2'b00;
    step();

    // Alloc wins over a same-cycle clear; ownership guards the clear.
    alloc_en = 1'b1; alloc_unit = 1'b0; alloc_addr = 5'd3;
    step();
    alloc_unit = 1'b1;
    req_valid = 2'b01; req_addr = {5'd0, 5'd3}; req_data = {32'h0, 32'h33}; #1;
    check_eq("race_ready", req_ready, 2'b01);
    step();
    alloc_en = 1'b0; chk_addr_2 = 5'd3; #1;
    check_eq("race_waddr", write_addr, 3);
    check_eq("race_busy", busy_2, 1);
    step();
    check_eq("mdu_no_clear", busy_2, 1);
    req_valid = 2'b10; req_addr = {5'd3, 5'd0}; req_data = {32'h44, 32'h0};
    step();
    req_valid = 2'b00;
    check_eq("lsu_clear", busy_2, 0);

    // Address 0: never busy, writes still forwarded.
    alloc_en = 1'b1; alloc_unit = 1'b0; alloc_addr = 5'd0;
    step();
    alloc_en = 1'b0; chk_addr_1 = 5'd0; #1;
    check_eq("addr0_busy", busy_1, 0);
    pipe_wen = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'h1;
    step();
    pipe_wen = 1'b0;
    check_eq("addr0_wen", write_en, 1);
    check_eq("addr0_waddr", write_addr, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
